chain_decoder_param: RTL and testbench

- Parametrised Freeman chain-code boundary decoder, successor to the fixed 64x64 decoder.
- Accepts a packed 3-bit direction stream over a byte valid/ready handshake, buffers it, and clears a DIM x DIM bitmap.
- Traces the boundary from a start pixel, one code per cycle, then checks length, bounds and closure.
- Exposes the bitmap through a registered row-read port; sits between the byte receiver and the display/verification logic.

---
 rtl/chain_decoder_param_if.sv | 18 +
 rtl/chain_decoder_param.sv | 212 +++++++++++++++++++++
 tb/tb_chain_decoder_param.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/chain_decoder_param_if.sv
// Byte-wide valid/ready stream carrying packed 3-bit chain codes.
interface chain_decoder_param_if;
  logic       code_valid;
  logic [7:0] code_byte;
  logic       code_ready;

  modport master (
    output code_valid,
    output code_byte,
    input  code_ready
  );

  modport slave (
    input  code_valid,
    input  code_byte,
    output code_ready
  );
endinterface

// File: rtl/chain_decoder_param.sv
// Freeman chain-code boundary decoder: buffers a packed 3-bit direction stream,
// clears a DIM x DIM bitmap, traces the boundary from a start pixel and checks
// length, bounds and closure. The bitmap is readable through a registered row port.
module chain_decoder_param #(
  parameter int unsigned DIM  = 64,
  parameter int unsigned CW   = $clog2(DIM),
  parameter int unsigned MAXC = 512,
  parameter int unsigned PW   = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  chain_decoder_param_if.slave code,
  input  logic                 start,
  input  logic [CW-1:0]        start_row,
  input  logic [CW-1:0]        start_col,
  input  logic [PW-1:0]        perimeter,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [1:0]           err_code,
  input  logic                 rd_en,
  input  logic [CW-1:0]        rd_addr,
  output logic [DIM-1:0]       rd_data,
  output logic                 rd_valid
);

  localparam int unsigned NBITS = 3 * MAXC;
  // Wide enough to hold BC + 8 at full buffer.
  localparam int unsigned BW    = $clog2(NBITS + 9);
  localparam logic [CW:0] One   = 1;

  typedef enum logic [2:0] {StIdle, StClear, StLoad, StTrace, StCheck, StDone} state_e;

  state_e           state_q, state_d;
  logic [BW-1:0]    bc_q, bc_d;
  logic [PW-1:0]    n_q, n_d, p_q, p_d;
  logic [CW-1:0]    clr_q, clr_d;
  logic [CW-1:0]    row_q, row_d, col_q, col_d;
  logic [CW-1:0]    sr_q, sr_d, sc_q, sc_d;
  logic             error_q, error_d;
  logic [1:0]       err_q, err_d;
  logic [NBITS-1:0] buf_q;
  logic [DIM-1:0]   bitmap_q [DIM];
  logic [DIM-1:0]   rd_data_q;
  logic             rd_valid_q;

  logic             room, accept, bad_len, have_codes, off_grid;
  logic [BW-1:0]    code_addr;
  logic [2:0]       dir;
  logic [CW:0]      nr, nc;

  assign room       = (bc_q + BW'(8)) <= BW'(NBITS);
  assign bad_len    = (perimeter == '0) || (32'(perimeter) > MAXC);
  assign have_codes = 32'(bc_q) >= (32'(p_q) * 32'd3);
  assign code_addr  = BW'(n_q) * BW'(3);
  assign dir        = buf_q[code_addr +: 3];

  assign code.code_ready = room && !reset &&
                           (state_q inside {StIdle, StClear, StLoad, StDone});
  assign accept          = code.code_valid && code.code_ready;

  assign busy     = state_q inside {StClear, StLoad, StTrace, StCheck};
  assign done     = (state_q == StDone);
  assign error    = error_q;
  assign err_code = err_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

  // Candidate next pixel; one extra MSB flags a step off either edge of the grid.
  always_comb begin
    nr = {1'b0, row_q};
    nc = {1'b0, col_q};
    unique case (dir)
      3'd0: nc = nc + One;
      3'd1: begin nr = nr - One; nc = nc + One; end
      3'd2: nr = nr - One;
      3'd3: begin nr = nr - One; nc = nc - One; end
      3'd4: nc = nc - One;
      3'd5: begin nr = nr + One; nc = nc - One; end
      3'd6: nr = nr + One;
      3'd7: begin nr = nr + One; nc = nc + One; end
    endcase
    off_grid = nr[CW] | nc[CW];
  end

  // Next-state logic for the frame sequencer and its datapath.
  always_comb begin
    state_d = state_q;
    bc_d    = bc_q;
    n_d     = n_q;
    p_d     = p_q;
    clr_d   = clr_q;
    row_d   = row_q;
    col_d   = col_q;
    sr_d    = sr_q;
    sc_d    = sc_q;
    error_d = error_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          sr_d  = start_row;
          sc_d  = start_col;
          row_d = start_row;
          col_d = start_col;
          p_d   = perimeter;
          n_d   = '0;
          clr_d = '0;
          if (bad_len) begin
            state_d = StDone;
            error_d = 1'b1;
            err_d   = 2'd1;
          end else begin
            state_d = StClear;
            error_d = 1'b0;
            err_d   = 2'd0;
          end
        end
      end
      StClear: begin
        clr_d = clr_q + CW'(1);
        if (clr_q == CW'(DIM - 1)) state_d = StLoad;
      end
      StLoad: begin
        if (have_codes) state_d = StTrace;
      end
      StTrace: begin
        if (off_grid) begin
          state_d = StDone;
          error_d = 1'b1;
          err_d   = 2'd2;
        end else begin
          row_d = nr[CW-1:0];
          col_d = nc[CW-1:0];
          if (n_q == p_q - PW'(1)) state_d = StCheck;
          else                     n_d = n_q + PW'(1);
        end
      end
      StCheck: begin
        state_d = StDone;
        if (row_q == sr_q && col_q == sc_q) begin
          error_d = 1'b0;
          err_d   = 2'd0;
        end else begin
          error_d = 1'b1;
          err_d   = 2'd3;
        end
      end
      default: state_d = StIdle;
    endcase
    if (accept) bc_d = bc_q + BW'(8);
    // Entering DONE discards the consumed frame; a later byte starts at bit 0.
    if (state_d == StDone && state_q != StDone) bc_d = '0;
  end

  // Sequencer and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      bc_q    <= '0;
      n_q     <= '0;
      p_q     <= '0;
      clr_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      sr_q    <= '0;
      sc_q    <= '0;
      error_q <= 1'b0;
      err_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      bc_q    <= bc_d;
      n_q     <= n_d;
      p_q     <= p_d;
      clr_q   <= clr_d;
      row_q   <= row_d;
      col_q   <= col_d;
      sr_q    <= sr_d;
      sc_q    <= sc_d;
      error_q <= error_d;
      err_q   <= err_d;
    end
  end

  // Code buffer write; contents beyond bc_q are never consumed, so no reset.
  always_ff @(posedge clk) begin
    if (accept) buf_q[bc_q +: 8] <= code.code_byte;
  end

  // Bitmap: one row cleared per CLEAR cycle, one pixel marked per TRACE cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DIM; i++) bitmap_q[i] <= '0;
    end else if (state_q == StClear) begin
      bitmap_q[clr_q] <= '0;
    end else if (state_q == StTrace) begin
      bitmap_q[row_q][col_q] <= 1'b1;
    end
  end

  // Registered row read port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= rd_en;
      if (rd_en) rd_data_q <= bitmap_q[rd_addr];
    end
  end

endmodule

// File: tb/tb_chain_decoder_param.sv
// Directed bench for chain_decoder_param with a behavioural trace model.
module tb_chain_decoder_param;
  localparam int DIM  = 64;
  localparam int CW   = 6;
  localparam int MAXC = 512;
  localparam int PW   = 10;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  chain_decoder_param_if bus ();

  logic           start;
  logic [CW-1:0]  start_row, start_col;
  logic [PW-1:0]  perimeter;
  logic           busy, done, error;
  logic [1:0]     err_code;
  logic           rd_en;
  logic [CW-1:0]  rd_addr;
  logic [DIM-1:0] rd_data;
  logic           rd_valid;

  chain_decoder_param #(.DIM(DIM), .MAXC(MAXC), .PW(PW)) dut (
    .clk       (clk),
    .reset     (reset),
    .code      (bus),
    .start     (start),
    .start_row (start_row),
    .start_col (start_col),
    .perimeter (perimeter),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .err_code  (err_code),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid)
  );

  int vectors = 0;
  int miscompares = 0;

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endfunction

  // Model state: accepted bytes of the current frame, expected bitmap and result.
  logic [7:0]     mq [256];
  int             mcnt = 0;
  logic [DIM-1:0] exp_map [DIM];
  int             fsr, fsc, fp;
  bit             exp_valid, arm_bad, good_pend, done_prev, rd_pend;
  logic           exp_e;
  logic [1:0]     exp_c;
  logic [CW-1:0]  rd_pa;
  int             dr_tab [8] = '{0, -1, -1, -1, 0, 1, 1, 1};
  int             dc_tab [8] = '{1, 1, 0, -1, -1, -1, 0, 1};

  function automatic void run_model();
    int r, c, nr, nc, dcode, k;
    for (int i = 0; i < DIM; i++) exp_map[i] = '0;
    r = fsr; c = fsc; exp_e = 1'b0; exp_c = 2'd0;
    for (int n = 0; n < fp; n++) begin
      dcode = 0;
      for (int b = 0; b < 3; b++) begin
        k = 3 * n + b;
        if (mq[k / 8][k % 8]) dcode += (1 << b);
      end
      exp_map[r][c] = 1'b1;
      nr = r + dr_tab[dcode];
      nc = c + dc_tab[dcode];
      if (nr < 0 || nr >= DIM || nc < 0 || nc >= DIM) begin
        exp_e = 1'b1; exp_c = 2'd2;
        return;
      end
      r = nr; c = nc;
    end
    if (r != fsr || c != fsc) begin
      exp_e = 1'b1; exp_c = 2'd3;
    end
  endfunction

  // Compare process: checks reads, result and code_ready against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        mcnt = 0;
        for (int i = 0; i < DIM; i++) exp_map[i] = '0;
        exp_valid = 0; arm_bad = 0; good_pend = 0; done_prev = 0; rd_pend = 0;
      end else begin
        if (rd_pend) check("rd_data", rd_data, exp_map[rd_pa]);
        check("rd_valid", rd_valid, rd_pend);
        if (arm_bad) begin
          exp_valid = 1; exp_e = 1'b1; exp_c = 2'd1; arm_bad = 0;
        end
        if (done && !done_prev) begin
          if (good_pend) begin
            run_model();
            exp_valid = 1; good_pend = 0;
          end
          mcnt = 0;
        end
        if (done && exp_valid) begin
          check("error", error, exp_e);
          check("err_code", err_code, exp_c);
        end
        if (!busy) check("code_ready", bus.code_ready, (mcnt * 8 + 8 <= 3 * MAXC) ? 1 : 0);
        if (bus.code_valid && bus.code_ready && mcnt < 256) begin
          mq[mcnt] = bus.code_byte;
          mcnt++;
        end
        if (start && !busy) begin
          fsr = int'(start_row); fsc = int'(start_col); fp = int'(perimeter);
          exp_valid = 0;
          if (fp == 0 || fp > MAXC) arm_bad = 1;
          else                      good_pend = 1;
        end
        rd_pend = rd_en;
        rd_pa   = rd_addr;
        done_prev = done;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int guard, output bit ok);
    bit acc;
    bus.code_valid = 1'b1;
    bus.code_byte  = b;
    ok = 0;
    for (int g = 0; g < guard && !ok; g++) begin
      @(negedge clk);
      acc = bus.code_ready;
      tick();
      ok = acc;
    end
    bus.code_valid = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    bit ok;
    send_byte(b, 200, ok);
    check("byte_accept", ok, 1);
  endtask

  task automatic do_start(input int r, input int c, input int p);
    start = 1'b1;
    start_row = CW'(r);
    start_col = CW'(c);
    perimeter = PW'(p);
    tick();
    start = 1'b0;
  endtask

  // lat counts edges from the one before start was raised to done visible.
  task automatic wait_done(input int limit, output int lat);
    int k = 0;
    while (!done && k < limit) begin
      tick();
      k++;
    end
    check("done_timeout", done, 1);
    lat = k + 1;
  endtask

  task automatic read_row(input int a, output logic [DIM-1:0] data);
    rd_en = 1'b1;
    rd_addr = CW'(a);
    tick();
    rd_en = 1'b0;
    data = rd_data;
  endtask

  task automatic read_all();
    for (int i = 0; i < DIM; i++) begin
      rd_en = 1'b1;
      rd_addr = CW'(i);
      tick();
    end
    rd_en = 1'b0;
    tick();
  endtask

  logic [7:0]     pat [3] = '{8'h20, 8'h08, 8'h82};
  logic [DIM-1:0] row;
  int             lat;
  int             acc_cnt;
  bit             ok;

  initial begin
    reset = 1'b1;
    start = 1'b0; start_row = '0; start_col = '0; perimeter = '0;
    rd_en = 1'b0; rd_addr = '0;
    bus.code_valid = 1'b0; bus.code_byte = '0;
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_err_code", err_code, 0);
    check("rst_code_ready", bus.code_ready, 0);
    check("rst_rd_valid", rd_valid, 0);
    reset = 1'b0;
    tick();
    check("idle_ready", bus.code_ready, 1);

    // Square: codes 0,6,4,2 from (10,10).
    send(8'h30); send(8'h05);
    do_start(10, 10, 4);
    wait_done(DIM + 50, lat);
    check("square_latency", lat, DIM + 7);
    check("square_error", error, 0);
    check("square_err_code", err_code, 0);
    read_row(10, row); check("square_row10", row, 64'hC00);
    read_row(11, row); check("square_row11", row, 64'hC00);
    read_all();

    // Bad length: rejected next cycle, bitmap kept.
    do_start(0, 0, 0);
    check("p0_done", done, 1);
    check("p0_busy", busy, 0);
    check("p0_err_code", err_code, 1);
    read_row(10, row); check("p0_row10_kept", row, 64'hC00);
    do_start(0, 0, MAXC + 1);
    check("pbig_done", done, 1);
    check("pbig_busy", busy, 0);
    check("pbig_err_code", err_code, 1);
    read_row(11, row); check("pbig_row11_kept", row, 64'hC00);

    // Open path: codes 0,0,0 from (5,5).
    send(8'h00); send(8'h00);
    do_start(5, 5, 3);
    wait_done(DIM + 50, lat);
    check("open_error", error, 1);
    check("open_err_code", err_code, 3);
    read_row(5, row); check("open_row5", row, 64'hE0);
    read_all();

    // Bounds: code 2 from row 0.
    send(8'h02);
    do_start(0, 5, 1);
    wait_done(DIM + 50, lat);
    check("bounds_latency", lat, DIM + 3);
    check("bounds_err_code", err_code, 2);
    read_row(0, row); check("bounds_row0", row, 64'h20);

    // Backpressure: 200 bytes offered, buffer holds 192.
    reset = 1'b1; tick(); reset = 1'b0; tick();
    acc_cnt = 0;
    for (int i = 0; i < 200; i++) begin
      send_byte(pat[i % 3], 3, ok);
      if (!ok) break;
      acc_cnt++;
    end
    check("bp_accepted", acc_cnt, 192);
    check("bp_ready_low", bus.code_ready, 0);
    do_start(20, 20, MAXC);
    wait_done(DIM + 600, lat);
    check("bp_latency", lat, DIM + MAXC + 3);
    check("bp_error", error, 0);
    read_row(20, row); check("bp_row20", row, 64'h300000);
    read_all();

    // Late data: start first, codes arrive well after CLEAR.
    do_start(10, 10, 4);
    repeat (DIM + 20) tick();
    check("late_busy", busy, 1);
    check("late_done", done, 0);
    send(8'h30); send(8'h05);
    wait_done(100, lat);
    check("late_error", error, 0);
    check("late_err_code", err_code, 0);
    read_row(10, row); check("late_row10", row, 64'hC00);
    read_row(11, row); check("late_row11", row, 64'hC00);

    // Reset while tracing.
    send(8'h30); send(8'h05);
    do_start(10, 10, 4);
    repeat (DIM + 2) tick();
    check("trace_busy", busy, 1);
    bus.code_valid = 1'b1;
    reset = 1'b1;
    #1;
    check("mid_busy", busy, 0);
    check("mid_done", done, 0);
    check("mid_error", error, 0);
    check("mid_err_code", err_code, 0);
    check("mid_code_ready", bus.code_ready, 0);
    check("mid_rd_valid", rd_valid, 0);
    bus.code_valid = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    read_row(10, row); check("mid_row10_zero", row, 64'h0);
    read_all();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running, required to finish");
    $fatal(1, "timeout");
  end

endmodule
